// File: rtl/hls_run_ctrl_if.sv
// rtl/hls_run_ctrl_if.sv - handshake bundle between host, HLS adder core and hls_run_ctrl
//
// Signals (directions as seen by the controller, modport slave):
//   inputs : run_req, host_req, adder_ready, adder_done, adder_idle, err_clr
//   outputs: run_ack, host_gnt, mem_sel, adder_start, busy, done_pulse,
//            run_count[CNT_W-1:0], timeout_err
// modport master is the mirror image, used by whatever drives the controller.

interface hls_run_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             run_req;
   logic             run_ack;
   logic             host_req;
   logic             host_gnt;
   logic             mem_sel;
   logic             adder_start;
   logic             adder_ready;
   logic             adder_done;
   logic             adder_idle;
   logic             busy;
   logic             done_pulse;
   logic [CNT_W-1:0] run_count;
   logic             err_clr;
   logic             timeout_err;

   modport slave (
      input  run_req, host_req, adder_ready, adder_done, adder_idle, err_clr,
      output run_ack, host_gnt, mem_sel, adder_start, busy, done_pulse,
             run_count, timeout_err
   );

   modport master (
      output run_req, host_req, adder_ready, adder_done, adder_idle, err_clr,
      input  run_ack, host_gnt, mem_sel, adder_start, busy, done_pulse,
             run_count, timeout_err
   );
endinterface

// File: rtl/hls_run_ctrl.sv
// rtl/hls_run_ctrl.sv - run sequencer and memory-mux owner for the HLS adder core
//
// Optional watchdog: define HLS_TIMEOUT_EN to enable the START/WAIT watchdog
// and the ERR state.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - hls_run_ctrl_if.slave: host run/memory requests, ap_ctrl_hs
//            handshake to the adder core, mux select, status and run counter

module hls_run_ctrl #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   hls_run_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HOST    = 3'd1,
      S_GRANT   = 3'd2,
      S_START   = 3'd3,
      S_WAIT    = 3'd4,
`ifdef HLS_TIMEOUT_EN
      S_ERR     = 3'd6,
`endif
      S_RELEASE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_count_q, run_count_d;
   logic             run_ack_q, run_ack_d;
   logic             host_gnt_q, host_gnt_d;
   logic             mem_sel_q, mem_sel_d;
   logic             adder_start_q, adder_start_d;
   logic             busy_q, busy_d;
   logic             done_pulse_q, done_pulse_d;
   logic             timeout_err_q, timeout_err_d;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef HLS_TIMEOUT_EN
   localparam int            WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_q, wd_d;
`else
   // Watchdog inputs and parameters have no function in this build.
   logic unused_cfg;
   assign unused_cfg = bus.err_clr & (TIMEOUT_CYCLES > 0);
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            // host wins a tie with a run request
            if (bus.host_req)     state_d = S_HOST;
            else if (bus.run_req) state_d = S_GRANT;
         end
         S_HOST: begin
            if (!bus.host_req) state_d = S_IDLE;
         end
         S_GRANT: begin
            // mux already points at the accelerator; wait for the core to idle
            if (bus.adder_idle) state_d = S_START;
         end
         S_START: begin
            if (bus.adder_ready && bus.adder_done) state_d = S_RELEASE;
            else if (bus.adder_ready)              state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.adder_done) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
`ifdef HLS_TIMEOUT_EN
         S_ERR: begin
            if (bus.err_clr) state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef HLS_TIMEOUT_EN
      // Terminal watchdog cycle: only a completion (move to RELEASE) escapes ERR.
      if ((state_q == S_START || state_q == S_WAIT) && wd_q == WD_LAST &&
          state_d != S_RELEASE) begin
         state_d = S_ERR;
      end
`endif
   end

`ifdef HLS_TIMEOUT_EN
   // Watchdog: zero on the first START cycle, +1 for every START/WAIT cycle.
   always_comb begin
      wd_d = wd_q;
      if (state_d == S_START && state_q != S_START) begin
         wd_d = '0;
      end else if (state_q == S_START || state_q == S_WAIT) begin
         wd_d = wd_q + WD_W'(1);
      end
   end
`endif

   // Registered outputs, decoded from the state being entered.
   always_comb begin
      run_ack_d     = (state_q == S_IDLE) && (state_d == S_GRANT);
      host_gnt_d    = (state_d == S_HOST);
      mem_sel_d     = (state_d == S_GRANT) || (state_d == S_START) || (state_d == S_WAIT);
      adder_start_d = (state_d == S_START);
      busy_d        = (state_d != S_IDLE) && (state_d != S_HOST);
      done_pulse_d  = (state_d == S_RELEASE);
      timeout_err_d = 1'b0;
`ifdef HLS_TIMEOUT_EN
      timeout_err_d = (state_d == S_ERR);
`endif
      run_count_d   = run_count_q;
      // RELEASE lasts exactly one cycle, so this increments once per run.
      if (state_d == S_RELEASE && run_count_q != CNT_MAX) begin
         run_count_d = run_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         run_count_q   <= '0;
         run_ack_q     <= 1'b0;
         host_gnt_q    <= 1'b0;
         mem_sel_q     <= 1'b0;
         adder_start_q <= 1'b0;
         busy_q        <= 1'b0;
         done_pulse_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_count_q   <= run_count_d;
         run_ack_q     <= run_ack_d;
         host_gnt_q    <= host_gnt_d;
         mem_sel_q     <= mem_sel_d;
         adder_start_q <= adder_start_d;
         busy_q        <= busy_d;
         done_pulse_q  <= done_pulse_d;
         timeout_err_q <= timeout_err_d;
      end
   end

`ifdef HLS_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`endif

   assign bus.run_ack     = run_ack_q;
   assign bus.host_gnt    = host_gnt_q;
   assign bus.mem_sel     = mem_sel_q;
   assign bus.adder_start = adder_start_q;
   assign bus.busy        = busy_q;
   assign bus.done_pulse  = done_pulse_q;
   assign bus.run_count   = run_count_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hls_run_ctrl.sv
// tb/tb_hls_run_ctrl.sv - directed self-checking bench for hls_run_ctrl

module tb_hls_run_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hls_run_ctrl_if #(.CNT_W(2)) bus ();

   hls_run_ctrl #(.CNT_W(2), .TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(negedge clk);
   endtask

   // Launch one run on an idle core that completes combinationally.
   // Returns with the controller in RELEASE; caller checks the results.
   task automatic do_run(output bit started);
      started = 1'b0;
      bus.run_req = 1'b1;
      step();
      bus.run_req = 1'b0;
      for (int i = 0; i < 8 && !started; i++) begin
         step();
         if (bus.adder_start === 1'b1) started = 1'b1;
      end
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.mem_sel !== 1'b0)     begin errors++; $display("FAIL reset_mem_sel got %b exp 0", bus.mem_sel); end
      checks++; if (bus.adder_start !== 1'b0) begin errors++; $display("FAIL reset_adder_start got %b exp 0", bus.adder_start); end
      checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.run_count !== 2'd0)   begin errors++; $display("FAIL reset_run_count got %0d exp 0", bus.run_count); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", bus.timeout_err); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if ({bus.run_ack, bus.host_gnt, bus.done_pulse} !== 3'b000) begin errors++; $display("FAIL reset_idle_outs got %b exp 000", {bus.run_ack, bus.host_gnt, bus.done_pulse}); end
   endtask

   task automatic test_basic();
      bus.run_req = 1'b1;
      step();
      checks++; if (bus.run_ack !== 1'b1)     begin errors++; $display("FAIL basic_run_ack got %b exp 1", bus.run_ack); end
      checks++; if (bus.mem_sel !== 1'b1)     begin errors++; $display("FAIL basic_grant_mem_sel got %b exp 1", bus.mem_sel); end
      checks++; if (bus.adder_start !== 1'b0) begin errors++; $display("FAIL basic_grant_start got %b exp 0", bus.adder_start); end
      bus.run_req = 1'b0;
      step();
      checks++; if (bus.adder_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b exp 1", bus.adder_start); end
      checks++; if (bus.run_ack !== 1'b0)     begin errors++; $display("FAIL basic_ack_pulse got %b exp 0", bus.run_ack); end
      bus.adder_ready = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      checks++; if (bus.adder_start !== 1'b0) begin errors++; $display("FAIL basic_start_1cyc got %b exp 0", bus.adder_start); end
      for (int i = 0; i < 4; i++) begin
         checks++; if ({bus.mem_sel, bus.done_pulse} !== 2'b10) begin errors++; $display("FAIL basic_wait%0d mem_sel/done got %b exp 10", i, {bus.mem_sel, bus.done_pulse}); end
         step();
      end
      bus.adder_done = 1'b1;
      step();
      bus.adder_done = 1'b0;
      checks++; if (bus.done_pulse !== 1'b1)  begin errors++; $display("FAIL basic_done_pulse got %b exp 1", bus.done_pulse); end
      checks++; if (bus.mem_sel !== 1'b0)     begin errors++; $display("FAIL basic_release_mem_sel got %b exp 0", bus.mem_sel); end
      checks++; if (bus.run_count !== 2'd1)   begin errors++; $display("FAIL basic_run_count got %0d exp 1", bus.run_count); end
      step();
      checks++; if ({bus.done_pulse, bus.busy} !== 2'b00) begin errors++; $display("FAIL basic_back_idle got %b exp 00", {bus.done_pulse, bus.busy}); end
   endtask

   task automatic test_priority();
      bit started;
      bus.run_req  = 1'b1;
      bus.host_req = 1'b1;
      step();
      checks++; if (bus.host_gnt !== 1'b1) begin errors++; $display("FAIL prio_host_gnt got %b exp 1", bus.host_gnt); end
      checks++; if (bus.run_ack !== 1'b0)  begin errors++; $display("FAIL prio_no_ack got %b exp 0", bus.run_ack); end
      checks++; if ({bus.mem_sel, bus.busy} !== 2'b00) begin errors++; $display("FAIL prio_host_mux got %b exp 00", {bus.mem_sel, bus.busy}); end
      step();
      step();
      checks++; if ({bus.host_gnt, bus.run_ack} !== 2'b10) begin errors++; $display("FAIL prio_hold got %b exp 10", {bus.host_gnt, bus.run_ack}); end
      bus.host_req = 1'b0;
      step();
      checks++; if ({bus.host_gnt, bus.run_ack} !== 2'b00) begin errors++; $display("FAIL prio_release got %b exp 00", {bus.host_gnt, bus.run_ack}); end
      step();
      checks++; if (bus.run_ack !== 1'b1) begin errors++; $display("FAIL prio_late_ack got %b exp 1", bus.run_ack); end
      bus.run_req = 1'b0;
      step();
      checks++; if (bus.adder_start !== 1'b1) begin errors++; $display("FAIL prio_start got %b exp 1", bus.adder_start); end
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      checks++; if (bus.run_count !== 2'd2) begin errors++; $display("FAIL prio_run_count got %0d exp 2", bus.run_count); end
      step();
      started = 1'b0;
   endtask

   task automatic test_busy_core();
      bus.adder_idle = 1'b0;
      bus.run_req    = 1'b1;
      step();
      bus.run_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if ({bus.adder_start, bus.mem_sel} !== 2'b01) begin errors++; $display("FAIL busy_grant%0d start/mem_sel got %b exp 01", i, {bus.adder_start, bus.mem_sel}); end
      end
      bus.adder_idle = 1'b1;
      step();
      checks++; if ({bus.adder_start, bus.mem_sel} !== 2'b11) begin errors++; $display("FAIL busy_start got %b exp 11", {bus.adder_start, bus.mem_sel}); end
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      checks++; if (bus.run_count !== 2'd3) begin errors++; $display("FAIL busy_run_count got %0d exp 3", bus.run_count); end
      step();
   endtask

   task automatic test_comb_core();
      // stray handshake in IDLE is ignored
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      checks++; if ({bus.done_pulse, bus.busy} !== 2'b00) begin errors++; $display("FAIL comb_stray_done got %b exp 00", {bus.done_pulse, bus.busy}); end
      bus.run_req = 1'b1;
      step();
      bus.run_req = 1'b0;
      step();
      checks++; if (bus.adder_start !== 1'b1) begin errors++; $display("FAIL comb_start got %b exp 1", bus.adder_start); end
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      checks++; if ({bus.done_pulse, bus.adder_start, bus.mem_sel} !== 3'b100) begin errors++; $display("FAIL comb_release got %b exp 100", {bus.done_pulse, bus.adder_start, bus.mem_sel}); end
      checks++; if (bus.run_count !== 2'd3) begin errors++; $display("FAIL comb_saturated got %0d exp 3", bus.run_count); end
      step();
      checks++; if ({bus.done_pulse, bus.busy} !== 2'b00) begin errors++; $display("FAIL comb_single_pulse got %b exp 00", {bus.done_pulse, bus.busy}); end
   endtask

   task automatic test_reset_mid_run();
      bus.run_req = 1'b1;
      step();
      bus.run_req = 1'b0;
      step();
      bus.adder_ready = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      step();
      checks++; if ({bus.mem_sel, bus.busy} !== 2'b11) begin errors++; $display("FAIL rstmid_in_wait got %b exp 11", {bus.mem_sel, bus.busy}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.mem_sel, bus.busy, bus.adder_start, bus.done_pulse} !== 4'b0000) begin errors++; $display("FAIL rstmid_outs got %b exp 0000", {bus.mem_sel, bus.busy, bus.adder_start, bus.done_pulse}); end
      checks++; if (bus.run_count !== 2'd0) begin errors++; $display("FAIL rstmid_run_count got %0d exp 0", bus.run_count); end
      step();
      rst_n = 1'b1;
      bus.adder_done = 1'b1;
      step();
      bus.adder_done = 1'b0;
      checks++; if ({bus.done_pulse, bus.busy} !== 2'b00) begin errors++; $display("FAIL rstmid_late_done got %b exp 00", {bus.done_pulse, bus.busy}); end
      checks++; if (bus.run_count !== 2'd0) begin errors++; $display("FAIL rstmid_late_count got %0d exp 0", bus.run_count); end
   endtask

`ifdef HLS_TIMEOUT_EN
   task automatic test_timeout();
      bit started;
      bit early;
      bus.run_req = 1'b1;
      step();
      bus.run_req = 1'b0;
      step();
      bus.adder_ready = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (bus.timeout_err !== 1'b0) early = 1'b1;
         step();
      end
      checks++; if (early || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", bus.timeout_err); end
      step();
      checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL wd_fire got %b exp 1", bus.timeout_err); end
      checks++; if ({bus.mem_sel, bus.adder_start, bus.busy, bus.done_pulse} !== 4'b0010) begin errors++; $display("FAIL wd_err_outs got %b exp 0010", {bus.mem_sel, bus.adder_start, bus.busy, bus.done_pulse}); end
      bus.adder_done = 1'b1;
      step();
      bus.adder_done = 1'b0;
      checks++; if ({bus.timeout_err, bus.done_pulse} !== 2'b10) begin errors++; $display("FAIL wd_sticky got %b exp 10", {bus.timeout_err, bus.done_pulse}); end
      checks++; if (bus.run_count !== 2'd0) begin errors++; $display("FAIL wd_no_count got %0d exp 0", bus.run_count); end
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      checks++; if ({bus.timeout_err, bus.busy} !== 2'b00) begin errors++; $display("FAIL wd_clear got %b exp 00", {bus.timeout_err, bus.busy}); end
      do_run(started);
      checks++; if (!started || bus.done_pulse !== 1'b1) begin errors++; $display("FAIL wd_next_run got start=%b done=%b exp 1 1", started, bus.done_pulse); end
      step();
      // completion on the terminal watchdog cycle must win
      bus.run_req = 1'b1;
      step();
      bus.run_req = 1'b0;
      step();
      bus.adder_ready = 1'b1;
      step();
      bus.adder_ready = 1'b0;
      for (int i = 0; i < 14; i++) step();
      bus.adder_done = 1'b1;
      step();
      bus.adder_done = 1'b0;
      checks++; if ({bus.done_pulse, bus.timeout_err} !== 2'b10) begin errors++; $display("FAIL wd_terminal_done got %b exp 10", {bus.done_pulse, bus.timeout_err}); end
      checks++; if (bus.run_count !== 2'd2) begin errors++; $display("FAIL wd_terminal_count got %0d exp 2", bus.run_count); end
      step();
   endtask
`endif

   task automatic test_saturation();
      bit          started;
      logic [1:0]  exp_cnt;
      apply_reset();
      for (int i = 1; i <= 5; i++) begin
         do_run(started);
         exp_cnt = (i > 3) ? 2'd3 : 2'(i);
         checks++; if (!started || bus.run_count !== exp_cnt) begin errors++; $display("FAIL sat_run%0d count got %0d exp %0d", i, bus.run_count, exp_cnt); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int acks  = 0;
      int dones = 0;
      bit bad_mux = 1'b0;
      bus.run_req     = 1'b1;
      bus.adder_ready = 1'b1;
      bus.adder_done  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.run_ack === 1'b1)    acks++;
         if (bus.done_pulse === 1'b1) dones++;
         if (bus.adder_start === 1'b1 && bus.mem_sel !== 1'b1) bad_mux = 1'b1;
      end
      bus.run_req     = 1'b0;
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      checks++; if (acks != 3)  begin errors++; $display("FAIL b2b_acks got %0d exp 3", acks); end
      checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones got %0d exp 3", dones); end
      checks++; if (bad_mux)    begin errors++; $display("FAIL b2b_start_without_mux got 1 exp 0"); end
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", bus.busy); end
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.run_req     = 1'b0;
      bus.host_req    = 1'b0;
      bus.adder_ready = 1'b0;
      bus.adder_done  = 1'b0;
      bus.adder_idle  = 1'b1;
      bus.err_clr     = 1'b0;
      step();
      test_reset();
      test_basic();
      test_priority();
      test_busy_core();
      test_comb_core();
      test_reset_mid_run();
`ifdef HLS_TIMEOUT_EN
      test_timeout();
`endif
      test_saturation();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
